// File: rtl/vga_timing_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 640x480@60 Hz timing constants and the colour-bar RGB table
//             shared by the sync generator and the test-pattern top level.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

   localparam int unsigned c_H_ACTIVE = 640;
   localparam int unsigned c_H_FP     = 16;
   localparam int unsigned c_H_SYNC   = 96;
   localparam int unsigned c_H_BP     = 48;
   localparam int unsigned c_V_ACTIVE = 480;
   localparam int unsigned c_V_FP     = 10;
   localparam int unsigned c_V_SYNC   = 2;
   localparam int unsigned c_V_BP     = 33;
   localparam int unsigned c_CLK_DIV  = 2;

   localparam int unsigned c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;  // 800
   localparam int unsigned c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;  // 525
   localparam int unsigned c_HS_START = c_H_ACTIVE + c_H_FP;                      // 656
   localparam int unsigned c_HS_END   = c_HS_START + c_H_SYNC - 1;                // 751
   localparam int unsigned c_VS_START = c_V_ACTIVE + c_V_FP;                      // 490
   localparam int unsigned c_VS_END   = c_VS_START + c_V_SYNC - 1;                // 491

   // {R,G,B} nibbles per bar, left to right across the visible line
   localparam logic [11:0] c_BAR_RGB [0:7] = '{
      12'hFFF,   // white
      12'hFF0,   // yellow
      12'h0FF,   // cyan
      12'h0F0,   // green
      12'hF0F,   // magenta
      12'hF00,   // red
      12'h00F,   // blue
      12'h000    // black
   };

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : Pixel-enable phase, horizontal/vertical counters and raw
//             (unregistered) decode of active area and sync pulses.
//  Ports    : clk          system clock, rising edge
//             rst          asynchronous active-high reset
//             o_pix_tick   high on the clock edge where counters advance
//             o_hc         horizontal counter, 0..H_TOTAL-1
//             o_active     current (hc,vc) lies in the visible area
//             o_hs_n       raw horizontal sync, active low
//             o_vs_n       raw vertical sync, active low
//             o_frame_end  current pixel is the last one of the frame
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = c_H_ACTIVE,
   parameter int unsigned H_FP     = c_H_FP,
   parameter int unsigned H_SYNC   = c_H_SYNC,
   parameter int unsigned H_BP     = c_H_BP,
   parameter int unsigned V_ACTIVE = c_V_ACTIVE,
   parameter int unsigned V_FP     = c_V_FP,
   parameter int unsigned V_SYNC   = c_V_SYNC,
   parameter int unsigned V_BP     = c_V_BP
) (
   input  logic       clk,
   input  logic       rst,
   output logic       o_pix_tick,
   output logic [9:0] o_hc,
   output logic       o_active,
   output logic       o_hs_n,
   output logic       o_vs_n,
   output logic       o_frame_end
);

   localparam logic [9:0] c_H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] c_V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] c_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] c_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] c_HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic       r_phase;
   logic [9:0] r_hc;
   logic [9:0] r_vc;
   logic       w_line_end;
   logic       w_frame_end;

   // Divide-by-2 enable: low on the first edge after reset release, so the
   // counters first advance on the second edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
      end
   end

   assign w_line_end  = (r_hc == c_H_LAST);
   assign w_frame_end = w_line_end && (r_vc == c_V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hc <= 10'd0;
         r_vc <= 10'd0;
      end else if (r_phase) begin
         if (w_line_end) begin
            r_hc <= 10'd0;
            r_vc <= w_frame_end ? 10'd0 : r_vc + 10'd1;
         end else begin
            r_hc <= r_hc + 10'd1;
         end
      end
   end

   assign o_pix_tick  = r_phase;
   assign o_hc        = r_hc;
   assign o_active    = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
   assign o_hs_n      = !((r_hc >= c_HS_FIRST) && (r_hc <= c_HS_LAST));
   assign o_vs_n      = !((r_vc >= c_VS_FIRST) && (r_vc <= c_VS_LAST));
   assign o_frame_end = w_frame_end;

endmodule
`default_nettype wire

// File: rtl/vga_test_pattern.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : vga_test_pattern
//  Purpose  : DE10-Lite VGA test pattern: eight vertical colour bars at
//             640x480@60 Hz from the 50 MHz clock, with a frame counter on
//             the red LEDs.
//  Ports    : MAX10_CLK1_50  50 MHz system clock, rising edge
//             reset          asynchronous active-high reset
//             VGA_R/G/B      4-bit colour channels (blank outside visible area)
//             VGA_HS/VGA_VS  sync outputs, active low
//             LEDR           frame counter, modulo 1024
//  Revision : 1.0  initial release
// ============================================================================
module vga_test_pattern
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = c_H_ACTIVE,
   parameter int unsigned H_FP     = c_H_FP,
   parameter int unsigned H_SYNC   = c_H_SYNC,
   parameter int unsigned H_BP     = c_H_BP,
   parameter int unsigned V_ACTIVE = c_V_ACTIVE,
   parameter int unsigned V_FP     = c_V_FP,
   parameter int unsigned V_SYNC   = c_V_SYNC,
   parameter int unsigned V_BP     = c_V_BP
) (
   input  logic       MAX10_CLK1_50,
   input  logic       reset,
   output logic [3:0] VGA_R,
   output logic [3:0] VGA_G,
   output logic [3:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [9:0] LEDR
);

   logic       w_pix_tick;
   logic [9:0] w_hc;
   logic       w_active;
   logic       w_hs_n;
   logic       w_vs_n;
   logic       w_frame_end;
   logic [2:0] w_bar;

   vga_sync_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_sync (
      .clk         (MAX10_CLK1_50),
      .rst         (reset),
      .o_pix_tick  (w_pix_tick),
      .o_hc        (w_hc),
      .o_active    (w_active),
      .o_hs_n      (w_hs_n),
      .o_vs_n      (w_vs_n),
      .o_frame_end (w_frame_end)
   );

   // Bar index = hc / (H_ACTIVE/8), done as a ladder of constant compares
   // instead of a divider. Only meaningful while hc is in the visible range.
   always_comb begin
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (w_hc >= 10'(k * H_ACTIVE / 8)) begin
            w_bar = 3'(k);
         end
      end
   end

   // Colour and both syncs are registered on the same tick so all five
   // outputs carry the same one-pixel latency.
   always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
      if (reset) begin
         VGA_R  <= 4'h0;
         VGA_G  <= 4'h0;
         VGA_B  <= 4'h0;
         VGA_HS <= 1'b1;
         VGA_VS <= 1'b1;
         LEDR   <= 10'd0;
      end else if (w_pix_tick) begin
         if (w_active) begin
            {VGA_R, VGA_G, VGA_B} <= c_BAR_RGB[w_bar];
         end else begin
            {VGA_R, VGA_G, VGA_B} <= 12'h000;
         end
         VGA_HS <= w_hs_n;
         VGA_VS <= w_vs_n;
         if (w_frame_end) begin
            LEDR <= LEDR + 10'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_test_pattern.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : tb_vga_test_pattern
//  Purpose  : Self-checking bench. One instance runs the full 640x480 timing
//             (horizontal timing, colour bars), a second runs a scaled-down
//             timing so vertical sync, blanking and the frame counter are
//             reached within a short run. Outputs are predicted from the
//             number of elapsed pixel ticks with plain arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_test_pattern;

   localparam int F_HA = 640, F_HF = 16, F_HS = 96, F_HB = 48;
   localparam int F_VA = 480, F_VF = 10, F_VS = 2,  F_VB = 33;
   localparam int S_HA = 64,  S_HF = 4,  S_HS = 8,  S_HB = 4;
   localparam int S_VA = 12,  S_VF = 2,  S_VS = 2,  S_VB = 3;
   localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

   localparam logic [23:0] c_RESET_OUT = 24'h003000;  // LEDR=0, HS=1, VS=1, RGB=0

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   logic [3:0] f_r, f_g, f_b, s_r, s_g, s_b;
   logic       f_hs, f_vs, s_hs, s_vs;
   logic [9:0] f_led, s_led;
   logic [23:0] w_full, w_small;

   assign w_full  = {f_led, f_hs, f_vs, f_r, f_g, f_b};
   assign w_small = {s_led, s_hs, s_vs, s_r, s_g, s_b};

   vga_test_pattern u_dut_full (
      .MAX10_CLK1_50 (clk),
      .reset         (rst),
      .VGA_R         (f_r),
      .VGA_G         (f_g),
      .VGA_B         (f_b),
      .VGA_HS        (f_hs),
      .VGA_VS        (f_vs),
      .LEDR          (f_led)
   );

   vga_test_pattern #(
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) u_dut_small (
      .MAX10_CLK1_50 (clk),
      .reset         (rst),
      .VGA_R         (s_r),
      .VGA_G         (s_g),
      .VGA_B         (s_b),
      .VGA_HS        (s_hs),
      .VGA_VS        (s_vs),
      .LEDR          (s_led)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int edges    = 0;   // rising edges since reset release
   bit phase1   = 1'b0;

   function automatic logic [11:0] bar_colour(input int b);
      case (b)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         5:       return 12'hF00;
         6:       return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   // Expected {LEDR, HS, VS, RGB} after n pixel ticks. Tick n shows pixel n-1.
   function automatic logic [23:0] model(input int n, input int ha, input int hf,
                                         input int hs, input int hb, input int va,
                                         input int vf, input int vs, input int vb);
      int htot, vtot, p, hc, vc;
      logic [11:0] rgb;
      logic        hsn, vsn;
      logic [9:0]  led;
      if (n == 0) return c_RESET_OUT;
      htot = ha + hf + hs + hb;
      vtot = va + vf + vs + vb;
      p    = n - 1;
      hc   = p % htot;
      vc   = (p / htot) % vtot;
      rgb  = (hc < ha && vc < va) ? bar_colour(hc / (ha / 8)) : 12'h000;
      hsn  = !(hc >= ha + hf && hc < ha + hf + hs);
      vsn  = !(vc >= va + vf && vc < va + vf + vs);
      led  = 10'((n / (htot * vtot)) % 1024);
      return {led, hsn, vsn, rgb};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_cycle();
      int n;
      n = rst ? 0 : edges / 2;
      check("full_model",  w_full,  model(n, F_HA, F_HF, F_HS, F_HB, F_VA, F_VF, F_VS, F_VB));
      check("small_model", w_small, model(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
      if (phase1) begin
         case (n)
            1:    begin check("bar0_first", w_full[11:0], 12'hFFF); check("hs_line_start", w_full[13], 1'b1); end
            80:   check("bar0_last",   w_full[11:0], 12'hFFF);
            81:   check("bar1_first",  w_full[11:0], 12'hFF0);
            560:  check("bar6_last",   w_full[11:0], 12'h00F);
            561:  check("bar7_first",  w_full[11:0], 12'h000);
            641:  check("hblank_640",  w_full[11:0], 12'h000);
            656:  check("hs_before",   w_full[13], 1'b1);
            657:  check("hs_fall_656", w_full[13], 1'b0);
            752:  check("hs_last_751", w_full[13], 1'b0);
            753:  check("hs_rise",     w_full[13], 1'b1);
            801:  check("line1_bar0",  w_full[11:0], 12'hFFF);
            961:  check("vblank_rgb",  w_small[11:0], 12'h000);
            1121: check("vs_fall",     w_small[12], 1'b0);
            1201: check("vs_line2",    w_small[12], 1'b0);
            1281: check("vs_rise",     w_small[12], 1'b1);
            1519: check("led_before",  w_small[23:14], 10'd0);
            1520: check("led_frame1",  w_small[23:14], 10'd1);
            3 * S_FRAME: check("led_frame3", w_small[23:14], 10'd3);
            default: ;
         endcase
      end
   endtask

   task automatic run_cycles(input int count);
      for (int i = 0; i < count; i++) begin
         @(posedge clk);
         if (!rst) edges++;
         @(negedge clk);
         compare_cycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      run_cycles(4);
      check("reset_full",  w_full,  c_RESET_OUT);
      check("reset_small", w_small, c_RESET_OUT);
      run_cycles(1);                       // now at t=100 ns, a falling edge
      rst    = 1'b0;
      phase1 = 1'b1;
      run_cycles(2 * 3 * S_FRAME + 2 * int'($urandom_range(100, 1400)));
      phase1 = 1'b0;

      // Asynchronous reset in the middle of a frame, between clock edges.
      #5 rst = 1'b1;
      edges = 0;
      #1;
      check("midreset_full",  w_full,  c_RESET_OUT);
      check("midreset_small", w_small, c_RESET_OUT);
      run_cycles(int'($urandom_range(1, 6)));
      rst = 1'b0;
      run_cycles(4000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_test_pattern.md
Name: vga_test_pattern

Overview:
- Top-level VGA test-pattern generator for the DE10-Lite board.
- Produces standard 640x480@60 Hz timing from the 50 MHz board clock using a divide-by-2 pixel enable (25 MHz pixel rate).
- Drives eight vertical colour bars on the 4-bit-per-channel VGA DAC, plus negative-polarity HSYNC and VSYNC.
- Shows a frame counter on the red LEDs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel

Ports:
- MAX10_CLK1_50  in   1   50 MHz system clock; all logic on its rising edge
- reset          in   1   asynchronous, active-high reset
- VGA_R          out  4   red channel
- VGA_G          out  4   green channel
- VGA_B          out  4   blue channel
- VGA_HS         out  1   horizontal sync, active low
- VGA_VS         out  1   vertical sync, active low
- LEDR           out  10  frame counter, modulo 1024

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: pixel-enable phase 0; hc=0; vc=0; VGA_R/G/B=0; VGA_HS=1; VGA_VS=1; LEDR=0.
- Pixel enable:
  - pix_en is a 1-bit phase counter. It is 0 on the first clock after reset release and 1 on the next, then alternates.
  - Counters and outputs update only on edges where pix_en=1, i.e. every 40 ns.
- Horizontal counter hc: 0..799 (H_TOTAL=800); wraps 799 -> 0.
- Vertical counter vc: 0..524 (V_TOTAL=525); increments only when hc wraps; wraps 524 -> 0.
- Decode from the counter values:
  - active = (hc<640) and (vc<480)
  - hs_n = 0 when 656<=hc<=751
  - vs_n = 0 when 490<=vc<=491
- Output registers:
  - R/G/B, HS and VS are registered from the decode on the same pixel tick, so all five have an identical 1-pixel latency and stay aligned.
  - No combinational paths to any output.
- Colour bars: bar index = hc/80 (0..7); each channel is 4'hF or 4'h0.
  - 0 white
  - 1 yellow (R,G)
  - 2 cyan (G,B)
  - 3 green
  - 4 magenta (R,B)
  - 5 red
  - 6 blue
  - 7 black
- Outside the active area all channels are 0 (blanking), including during sync.
- LEDR:
  - Increments by 1 on the pixel tick where hc=799 and vc=524 (end of frame).
  - Wraps 1023 -> 0.
- Reset mid-frame: all state returns immediately (asynchronously) to the reset values; the next frame starts at hc=0, vc=0 after release.
- Width rules:
  - hc and vc are 10 bits.
  - Bar index uses an unsigned compare/divide by 80 over the range 0..639.
  - No signed arithmetic.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants above and the derived H_TOTAL, V_TOTAL, sync start/end values
  - the 8-entry colour-bar RGB constant table (12 bits per entry)
- Sub-module vga_sync_gen holds the pixel enable, hc/vc counters, active flag and raw sync decode.
- The top level adds the colour-bar lookup, output registers and LED frame counter.

Test Plan:
- Reset held 100 ns, then released -> during reset HS=1, VS=1, RGB=0, LEDR=0; first counter advance occurs on the second clock edge after release.
- HS timing -> HS period 32,000 ns (800 pixels); low pulse 3,840 ns; falling edge 656 pixel ticks after the line start.
- VS timing over 2 frames -> VS period 16.8 ms (525 lines); low for 64,000 ns (2 lines); falling edge at line 490.
- Colour bars on line 0:
  - pixels 0..79 -> RGB=FFF
  - pixels 80..159 -> FF0
  - pixels 560..639 -> 000
  - pixel 640 onward -> 000
- Blanking on vertical lines 480..524 -> RGB=000 at every hc.
- Frame counter and mid-frame reset:
  - After 3 complete frames -> LEDR=3.
  - Reset asserted mid-frame -> immediately HS=1, VS=1, RGB=0, LEDR=0.
